// File: rtl/qbcd_pkg.sv
// Shared definitions for the Qalu binary-to-BCD converter: FSM encoding,
// digit constants and elaboration-time sizing helpers.
package qbcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd5;

    // Bits needed to hold the value n (at least 1).
    function automatic int cnt_bits(input int n);
        int b;
        b = 0;
        for (int v = n; v > 0; v = v >> 1) begin
            b++;
        end
        return (b == 0) ? 1 : b;
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/qbcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module qbcd_digit_adj
    import qbcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adj
);

    assign adj = (digit >= ADJ_THRESH) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/qalu_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) behind the Qalu ALU.
// Define QBCD_SIGNED_EN to treat in_data as two's complement and add the out_neg port.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// SHIFT | one add-3/shift step per cycle, WIDTH steps
// DONE  | result held on out_* until out_ready
module qalu_bcd_conv
    import qbcd_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_carry,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] out_bcd,
    output logic                    out_carry,
    output logic                    busy
`ifdef QBCD_SIGNED_EN
    ,
    output logic                    out_neg
`endif
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam int BCD_N = BCD_W * DIGITS;

    if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_size_check
        $error("qalu_bcd_conv: DIGITS too small for WIDTH");
    end

    state_t             state;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_N-1:0]   bcd_sr;
    logic [BCD_N-1:0]   adj_bcd;
    logic [CNT_W-1:0]   cnt;
    logic               carry_r;

    logic [BCD_N+WIDTH-1:0] shifted;
    logic [BCD_N-1:0]       bcd_next;
    logic [WIDTH-1:0]       bin_next;
    logic [WIDTH-1:0]       load_bin;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        qbcd_digit_adj u_adj (
            .digit (bcd_sr[d*BCD_W +: BCD_W]),
            .adj   (adj_bcd[d*BCD_W +: BCD_W])
        );
    end

    // The top bit of the adjusted BCD field falls off; it is always 0 for legal sizing.
    assign shifted  = {adj_bcd, bin_sr} << 1;
    assign bcd_next = shifted[BCD_N+WIDTH-1 -: BCD_N];
    assign bin_next = shifted[WIDTH-1:0];

`ifdef QBCD_SIGNED_EN
    logic neg_r;
    // Most negative input wraps to 2^(WIDTH-1), which is still the correct magnitude unsigned.
    assign load_bin = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
`else
    assign load_bin = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_carry <= 1'b0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            cnt       <= '0;
            carry_r   <= 1'b0;
`ifdef QBCD_SIGNED_EN
            neg_r     <= 1'b0;
            out_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr   <= load_bin;
                        bcd_sr   <= '0;
                        carry_r  <= in_carry;
                        cnt      <= CNT_W'(WIDTH);
`ifdef QBCD_SIGNED_EN
                        neg_r    <= in_data[WIDTH-1];
`endif
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_sr <= bcd_next;
                    bin_sr <= bin_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_bcd   <= bcd_next;
                        out_valid <= 1'b1;
                        out_carry <= carry_r;
`ifdef QBCD_SIGNED_EN
                        out_neg   <= neg_r;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qalu_bcd_conv.sv
// Scoreboard bench for qalu_bcd_conv: an input monitor pushes arithmetic BCD
// expectations at each accept, an output monitor pops and compares.
module tb_qalu_bcd_conv;

    localparam int WIDTH  = 7;
    localparam int DIGITS = 3;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                carry;
        logic                neg;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  in_carry;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_carry;
    logic                  busy;
`ifdef QBCD_SIGNED_EN
    logic                  out_neg;
`endif

    qalu_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_carry (out_carry),
        .busy      (busy)
`ifdef QBCD_SIGNED_EN
        ,
        .out_neg   (out_neg)
`endif
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   acc_q[$];
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    // Reference: decimal digits by division, sign by range.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic c);
        exp_t e;
        int   v;
        v = int'(d);
        e.neg = 1'b0;
`ifdef QBCD_SIGNED_EN
        if (v >= (1 << (WIDTH-1))) begin
            v     = (1 << WIDTH) - v;
            e.neg = 1'b1;
        end
`endif
        e.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.carry = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                tests++;
                if (sb.size() != 0) begin
                    fails++;
                    $display("FAIL accept_pending: accepted with %0d results outstanding, required 0", sb.size());
                end
                sb.push_back(model(in_data, in_carry));
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_valid) begin
                tests++;
                if (acc_q.size() == 0) begin
                    fails++;
                    $display("FAIL latency: out_valid rose with no accepted input");
                end else begin
                    int lat;
                    lat = cyc - acc_q.pop_front();
                    if (lat != WIDTH) begin
                        fails++;
                        $display("FAIL latency: got %0d edges, required %0d", lat, WIDTH);
                    end
                end
            end
            if (out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out: out_valid with empty scoreboard, out_bcd=%0h", out_bcd);
                end else begin
                    exp_t e;
                    logic neg_got;
                    e = sb[0];
`ifdef QBCD_SIGNED_EN
                    neg_got = out_neg;
`else
                    neg_got = 1'b0;
`endif
                    if (out_bcd !== e.bcd || out_carry !== e.carry || neg_got !== e.neg
                        || in_ready !== 1'b0 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL result: got bcd=%0h carry=%0b neg=%0b in_ready=%0b busy=%0b, required bcd=%0h carry=%0b neg=%0b in_ready=0 busy=0",
                                 out_bcd, out_carry, neg_got, in_ready, busy, e.bcd, e.carry, e.neg);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic check_idle(input string name);
        tests++;
        if (out_valid !== 1'b0 || out_bcd !== '0 || out_carry !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: got valid=%0b bcd=%0h carry=%0b busy=%0b in_ready=%0b, required 0/0/0/0/1",
                     name, out_valid, out_bcd, out_carry, busy, in_ready);
        end
    endtask

    // Returns #1 after the accept edge with in_valid still driven.
    task automatic wait_accept();
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout: in_ready never seen within %0d cycles", n);
        end else if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy: got %0b after accept, required 1", busy);
        end
    endtask

    task automatic send(input int v, input bit c);
        in_data  = WIDTH'(v);
        in_carry = c;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int hold);
        int n;
        if (hold > 0) begin
            out_ready = 1'b0;
            n = 0;
            while (!out_valid && n < 60) begin
                @(posedge clk);
                #1;
                n++;
            end
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
        end else if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_handshake: got in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_carry  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset_state");

        send(127, 1'b0); drain(0);
        send(9, 1'b1);   drain(0);
        send(19, 1'b0);  drain(5);

        // Back-to-back with in_valid held high across both accepts.
        in_data  = WIDTH'(21);
        in_carry = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        in_data  = WIDTH'(100);
        in_carry = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        drain(0);

        // Reset during the third SHIFT cycle of 99.
        send(99, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_idle("mid_reset");
        sb.delete();
        acc_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_output: got out_valid=%0b, required 0", out_valid);
            end
        end
        send(0, 1'b0); drain(0);

`ifdef QBCD_SIGNED_EN
        send(7'h73, 1'b0); drain(0);
        send(7'h40, 1'b1); drain(1);
`endif

        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
            drain(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
